ser_tx: RTL and testbench

- Parallel-to-serial transmitter. Takes BW-bit words over a valid/ready handshake and drives them one bit per clk onto a 1-bit serial lane.
- Includes frame and start markers.
- Transmit-side counterpart of the registered 1-bit capture lanes in the design. Drives a single-bit input of a downstream sampling block.

---
 rtl/ser_pkg.sv | 18 +
 rtl/ser_tx_if.sv | 16 +
 rtl/ser_shreg.sv | 50 +++++
 rtl/ser_tx.sv | 109 ++++++++++
 tb/tb_ser_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serial transmitter: state encoding and counter sizing.
// The gap counter is 4 bits wide, so GAP may be at most 15.
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam int GAP_CW = 4;

  function automatic int cnt_w(input int bw);
    return $clog2(bw + 1);
  endfunction

endpackage

// File: rtl/ser_tx_if.sv
// Word handshake in, serial lane out. The master side supplies words; the slave
// side is the transmitter.
interface ser_tx_if #(parameter int BW = 8) ();

  logic [BW-1:0] di;
  logic          di_valid;
  logic          di_ready;
  logic          so;
  logic          so_frame;
  logic          so_start;
  logic          busy;

  modport master (output di, di_valid, input di_ready, so, so_frame, so_start, busy);
  modport slave  (input di, di_valid, output di_ready, so, so_frame, so_start, busy);

endinterface

// File: rtl/ser_shreg.sv
// Load/shift register with a registered serial output; q is 0 on any cycle with
// no load or shift. A fill bit enters at the tail on every load or shift.
module ser_shreg
  import ser_pkg::*;
#(
  parameter int BW        = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [BW-1:0] d,
  input  logic          fill,
  output logic          q
);

  logic [BW-1:0] sr;
  logic [BW-1:0] src;
  logic [BW-1:0] nxt;
  logic [BW:0]   ext;
  logic          head;

  always_comb begin
    src  = load ? d : sr;
    head = MSB_FIRST ? src[BW-1] : src[0];
    ext  = '0;
    nxt  = '0;
    if (MSB_FIRST) begin
      ext = {src, fill};
      nxt = ext[BW-1:0];
    end else begin
      ext = {fill, src};
      nxt = ext[BW:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      q  <= 1'b0;
    end else if (load || shift) begin
      sr <= nxt;
      q  <= head;
    end else begin
      q  <= 1'b0;
    end
  end

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: word accepted at edge N shows its first bit the next
// cycle; di_ready only in IDLE or on the last frame bit when GAP=0. SER_TX_PARITY_EN adds an even-parity bit.
module ser_tx
  import ser_pkg::*;
#(
  parameter int BW        = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic   clk,
  input  logic   rst,
  ser_tx_if.slave bus
);

  localparam int              CW   = cnt_w(BW);
  localparam logic [CW-1:0]   LAST = CW'(BW - 1);
  // The IDLE cycle that accepts the next word is itself one of the GAP idle lane cycles.
  localparam state_t              POST      = (GAP > 1) ? ST_GAP : ST_IDLE;
  localparam logic [GAP_CW-1:0]   GAP_INIT  = (GAP > 1) ? GAP_CW'(GAP - 2) : '0;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [GAP_CW-1:0]   gcnt;
  logic                frame_q;
  logic                start_q;
  logic                so_q;
  logic                last_bit;
  logic                fin;
  logic                ready;
  logic                accept;
  logic                shift;
  logic                fill;

  always_comb begin
    last_bit = (state == ST_SHIFT) && (cnt == LAST);
`ifdef SER_TX_PARITY_EN
    // Parity rides in the shift register's tail, computed from the word at load.
    fin   = (state == ST_PAR);
    shift = (state == ST_SHIFT);
    fill  = ^bus.di;
`else
    fin   = last_bit;
    shift = (state == ST_SHIFT) && !last_bit;
    fill  = 1'b0;
`endif
    ready  = !rst && ((state == ST_IDLE) || (fin && (GAP == 0)));
    accept = ready && bus.di_valid;
  end

  ser_shreg #(.BW(BW), .MSB_FIRST(MSB_FIRST)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift),
    .d     (bus.di),
    .fill  (fill),
    .q     (so_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      gcnt    <= '0;
      frame_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= accept;
      frame_q <= accept;
      if (accept) begin
        state <= ST_SHIFT;
        cnt   <= '0;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (!last_bit) begin
              cnt     <= cnt + 1'b1;
              frame_q <= 1'b1;
            end else begin
`ifdef SER_TX_PARITY_EN
              state   <= ST_PAR;
              frame_q <= 1'b1;
`else
              state   <= POST;
              gcnt    <= GAP_INIT;
`endif
            end
          end
          ST_PAR: begin
            state <= POST;
            gcnt  <= GAP_INIT;
          end
          ST_GAP: begin
            if (gcnt == '0) state <= ST_IDLE;
            else            gcnt  <= gcnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.so       = so_q;
  assign bus.so_frame = frame_q;
  assign bus.so_start = start_q;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.di_ready = ready;

endmodule

// File: tb/tb_ser_tx.sv
// Bench for ser_tx: four configurations driven with directed and random word streams,
// each lane cycle compared against a frame-level model of the serial output.
module tb_ser_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ser_tx_if #(.BW(8)) ia ();
  ser_tx_if #(.BW(8)) ib ();
  ser_tx_if #(.BW(8)) ic ();
  ser_tx_if #(.BW(1)) id ();

  ser_tx #(.BW(8), .MSB_FIRST(1'b1), .GAP(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  ser_tx #(.BW(8), .MSB_FIRST(1'b0), .GAP(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  ser_tx #(.BW(8), .MSB_FIRST(1'b1), .GAP(3)) dut_c (.clk(clk), .rst(rst), .bus(ic));
  ser_tx #(.BW(1), .MSB_FIRST(1'b1), .GAP(0)) dut_d (.clk(clk), .rst(rst), .bus(id));

  int bws  [4] = '{8, 8, 8, 1};
  int msbs [4] = '{1, 0, 1, 1};
  int gaps [4] = '{0, 0, 3, 0};

  int checks   = 0;
  int failures = 0;

  logic [7:0] words [16];
  int         nwords;
  logic [4:0] expq [$];

  task automatic drive(input int which, input logic v, input logic [7:0] d);
    case (which)
      0:       begin ia.di_valid = v; ia.di = d;    end
      1:       begin ib.di_valid = v; ib.di = d;    end
      2:       begin ic.di_valid = v; ic.di = d;    end
      default: begin id.di_valid = v; id.di = d[0]; end
    endcase
  endtask

  // {so, so_frame, so_start, busy, di_ready}
  function automatic logic [4:0] sample(input int which);
    case (which)
      0:       return {ia.so, ia.so_frame, ia.so_start, ia.busy, ia.di_ready};
      1:       return {ib.so, ib.so_frame, ib.so_start, ib.busy, ib.di_ready};
      2:       return {ic.so, ic.so_frame, ic.so_start, ic.busy, ic.di_ready};
      default: return {id.so, id.so_frame, id.so_start, id.busy, id.di_ready};
    endcase
  endfunction

  // Lane model: frames of data bits (plus optional parity) separated by GAP idle cycles.
  task automatic build_exp(input int which);
    int bw, msb, gap, ones, flen;
    logic fb [$];
    bw  = bws[which];
    msb = msbs[which];
    gap = gaps[which];
    expq.delete();
    for (int i = 0; i < nwords; i++) begin
      fb.delete();
      ones = 0;
      for (int b = 0; b < bw; b++) begin
        fb.push_back(words[i][(msb != 0) ? (bw - 1 - b) : b]);
        ones += int'(words[i][b]);
      end
`ifdef SER_TX_PARITY_EN
      fb.push_back(logic'(ones % 2));
`endif
      flen = fb.size();
      for (int k = 0; k < flen; k++)
        expq.push_back({fb[k], 1'b1, logic'(k == 0), 1'b1, logic'(k == flen - 1 && gap == 0)});
      if (i < nwords - 1) begin
        for (int g = 0; g < gap; g++)
          expq.push_back({3'b000, logic'(g < gap - 1), logic'(g == gap - 1)});
      end else begin
        for (int g = 0; g < gap + 3; g++)
          expq.push_back({3'b000, logic'(g < gap - 1), logic'(!(g < gap - 1))});
      end
    end
  endtask

  task automatic run_stream(input string name, input int which);
    int idx = 0, got = 0, budget = 0;
    logic v = 1'b1, acc, started = 1'b0;
    logic [4:0] s;
    build_exp(which);
    @(negedge clk);
    drive(which, 1'b1, words[0]);
    while (got < expq.size() && budget < 1000) begin
      #1;
      s   = sample(which);
      acc = v && s[0];
      @(negedge clk);
      budget++;
      if (acc) begin
        started = 1'b1;
        idx++;
        if (idx < nwords) drive(which, 1'b1, words[idx]);
        else begin drive(which, 1'b0, 8'($urandom)); v = 1'b0; end
      end
      if (started) begin
        s = sample(which);
        checks++;
        if (s !== expq[got]) begin
          failures++;
          $display("FAIL %s cycle %0d {so,frame,start,busy,rdy} got=%b exp=%b", name, got, s, expq[got]);
        end
        got++;
      end
    end
    if (got < expq.size()) begin
      checks++;
      failures++;
      $display("FAIL %s timeout after %0d of %0d lane cycles", name, got, expq.size());
    end
    drive(which, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    logic [4:0] s;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      s = sample(w);
      checks++;
      if (s !== 5'b00000) begin failures++; $display("FAIL reset_hold dut%0d got=%b exp=00000", w, s); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      s = sample(w);
      checks++;
      if (s !== 5'b00001) begin failures++; $display("FAIL reset_idle dut%0d got=%b exp=00001", w, s); end
    end
  endtask

  task automatic test_single();
    words[0] = 8'hA5; nwords = 1;
    run_stream("single_a5", 0);
  endtask

  task automatic test_back_to_back();
    words[0] = 8'h01; words[1] = 8'h80; nwords = 2;
    run_stream("b2b_lsb", 1);
  endtask

  task automatic test_gap();
    words[0] = 8'($urandom); words[1] = 8'($urandom); nwords = 2;
    run_stream("gap3", 2);
  endtask

  task automatic test_reset_mid_frame();
    logic [4:0] s;
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    s = sample(0);
    checks++;
    if (s !== 5'b11110) begin failures++; $display("FAIL midrst_bit1 got=%b exp=11110", s); end
    repeat (3) @(negedge clk);
    s = sample(0);
    checks++;
    if (s !== 5'b11010) begin failures++; $display("FAIL midrst_bit4 got=%b exp=11010", s); end
    rst = 1'b1;
    @(negedge clk);
    s = sample(0);
    checks++;
    if (s !== 5'b00000) begin failures++; $display("FAIL midrst_abort got=%b exp=00000", s); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s = sample(0);
      checks++;
      if (s !== 5'b00001) begin failures++; $display("FAIL midrst_idle%0d got=%b exp=00001", k, s); end
    end
    words[0] = 8'h3C; nwords = 1;
    run_stream("after_rst_3c", 0);
  endtask

  task automatic test_parity();
    words[0] = 8'h07; nwords = 1;
    run_stream("par_07", 0);
    words[0] = 8'h03; nwords = 1;
    run_stream("par_03", 0);
  endtask

  task automatic test_bw1();
    words[0] = 8'h01; words[1] = 8'h00; words[2] = 8'h01; nwords = 3;
    run_stream("bw1_101", 3);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 4; w++) begin
        nwords = int'($urandom_range(1, 6));
        for (int i = 0; i < nwords; i++) words[i] = 8'($urandom);
        run_stream($sformatf("rand%0d_dut%0d", r, w), w);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 4; w++) drive(w, 1'b0, 8'h00);
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid_frame();
    test_parity();
    test_bw1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
